// File: rtl/wb_fifo_drain_pkg.sv
// Shared cache types: write-buffer entry layout and drain engine states.
package cache_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_BW = WB_DW / 8;

  // Field order matches the FIFO packing {addr, byteenable, data}, addr in the MSBs.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_BW-1:0] be;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_e;

  function automatic int word_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_fifo_drain_if.sv
// FIFO read port and Avalon-style write bus seen by the write-buffer drain engine.
interface wb_fifo_drain_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int EW = AW + DW/8 + DW;

  logic            fifo_empty;
  logic            fifo_read;
  logic [EW-1:0]   fifo_readData;
  logic [AW-1:0]   av_address;
  logic            av_write;
  logic [DW-1:0]   av_writedata;
  logic [DW/8-1:0] av_byteenable;
  logic            av_waitrequest;

  modport master (
    input  fifo_empty, fifo_readData, av_waitrequest,
    output fifo_read, av_address, av_write, av_writedata, av_byteenable
  );

  modport slave (
    output fifo_empty, fifo_readData, av_waitrequest,
    input  fifo_read, av_address, av_write, av_writedata, av_byteenable
  );
endinterface

// File: rtl/wb_fifo_drain.sv
// Write-buffer drain engine: pops store entries in order and issues one bus write per
// entry, with flush handshake, word-granular hazard check and sticky bus-timeout flag.
module wb_fifo_drain
  import cache_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rest,
  wb_fifo_drain_if.master  bus,
  input  logic             flush_req,
  output logic             flush_done,
  input  logic [AW-1:0]    chk_addr,
  output logic             chk_hit,
  output logic             busy,
  output logic             err
);

  localparam int BW  = DW / 8;
  localparam int EW  = AW + BW + DW;
  localparam int LSB = word_lsb(DW);
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX      = CW'(TIMEOUT);
  localparam logic [AW-1:0] WORD_MASK = ~((AW'(1) << LSB) - AW'(1));

  drain_state_e  state_q, state_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [BW-1:0] hold_be_q, hold_be_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          flush_pend_q, flush_pend_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic          pop;

  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_be_d    = hold_be_q;
    hold_data_d  = hold_data_q;
    flush_pend_d = flush_pend_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    // A pop is only taken when the holding register is free or retiring this cycle.
    pop = !rest && !bus.fifo_empty && (state_q == IDLE || !bus.av_waitrequest);

    case (state_q)
      IDLE: begin
        if (pop) state_d = WRITE;
      end
      WRITE: begin
        if (bus.av_waitrequest) begin
          if (TIMEOUT != 0 && wait_cnt_q != TMAX) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          wait_cnt_d = '0;
          if (!pop) state_d = IDLE;
        end
      end
    endcase

    if (pop) begin
      hold_addr_d = bus.fifo_readData[EW-1 -: AW];
      hold_be_d   = bus.fifo_readData[DW +: BW];
      hold_data_d = bus.fifo_readData[DW-1:0];
    end

    if (TIMEOUT != 0 && wait_cnt_d == TMAX) err_d = 1'b1;

    // A request landing on the completing cycle is absorbed into that completion.
    flush_done = !rest && flush_pend_q && state_q == IDLE && bus.fifo_empty;
    if (flush_done)     flush_pend_d = 1'b0;
    else if (flush_req) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_be_q    <= '0;
      hold_data_q  <= '0;
      flush_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_be_q    <= hold_be_d;
      hold_data_q  <= hold_data_d;
      flush_pend_q <= flush_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  assign bus.fifo_read     = pop;
  assign bus.av_write      = (state_q == WRITE);
  assign bus.av_address    = hold_addr_q;
  assign bus.av_byteenable = hold_be_q;
  assign bus.av_writedata  = hold_data_q;

  assign chk_hit = (state_q == WRITE) && (((chk_addr ^ hold_addr_q) & WORD_MASK) == '0);
  assign busy    = (state_q != IDLE) || !bus.fifo_empty;
  assign err     = err_q;

endmodule

// File: tb/tb_wb_fifo_drain.sv
// Directed bench for wb_fifo_drain: reset, back-to-back, stall/hazard, flush, timeout.
module tb_wb_fifo_drain;
  import cache_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rest;
  logic          flushReq;
  logic          flushDone;
  logic [AW-1:0] chkAddr;
  logic          chkHit;
  logic          busy;
  logic          err;

  int checkCount = 0;
  int passCount  = 0;

  wb_entry_t fq[$];

  wb_fifo_drain_if #(.AW(AW), .DW(DW)) bus();

  wb_fifo_drain #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rest       (rest),
    .bus        (bus),
    .flush_req  (flushReq),
    .flush_done (flushDone),
    .chk_addr   (chkAddr),
    .chk_hit    (chkHit),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic refreshFifo();
    bus.fifo_empty    = (fq.size() == 0);
    bus.fifo_readData = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic pushEntry(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wb_entry_t e;
    e.addr = a;
    e.be   = be;
    e.data = d;
    fq.push_back(e);
    refreshFifo();
  endtask

  task automatic applyStimulus(input logic r, input logic fr, input logic wr, input logic [31:0] ca);
    rest               = r;
    flushReq           = fr;
    bus.av_waitrequest = wr;
    chkAddr            = ca;
    refreshFifo();
    #1;
  endtask

  // The FIFO model pops on the edge where the engine's pop strobe was high.
  task automatic tick();
    logic popped;
    popped = bus.fifo_read;
    @(posedge clk);
    #1;
    if (popped && fq.size() != 0) void'(fq.pop_front());
    refreshFifo();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkBus(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    checkOutput({tag, ".av_write"}, 64'(bus.av_write), 64'(1'b1));
    checkOutput({tag, ".av_address"}, 64'(bus.av_address), 64'(a));
    checkOutput({tag, ".av_byteenable"}, 64'(bus.av_byteenable), 64'(be));
    checkOutput({tag, ".av_writedata"}, 64'(bus.av_writedata), 64'(d));
  endtask

  logic [31:0] b2bAddr [3] = '{32'h100, 32'h104, 32'h108};
  logic [3:0]  b2bBe   [3] = '{4'hF, 4'h3, 4'hC};
  logic [31:0] b2bData [3] = '{32'hA, 32'hB, 32'hC};
  logic        flWait  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        flReq   [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset with a non-empty FIFO: nothing may be popped or written.
    pushEntry(32'h900, 4'hF, 32'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("rst[%0d].fifo_read", i), 64'(bus.fifo_read), 64'(0));
      checkOutput($sformatf("rst[%0d].av_write", i), 64'(bus.av_write), 64'(0));
      checkOutput($sformatf("rst[%0d].err", i), 64'(err), 64'(0));
      checkOutput($sformatf("rst[%0d].flush_done", i), 64'(flushDone), 64'(0));
      checkOutput($sformatf("rst[%0d].chk_hit", i), 64'(chkHit), 64'(0));
      checkOutput($sformatf("rst[%0d].av_address", i), 64'(bus.av_address), 64'(0));
      tick();
    end
    fq.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle.busy", 64'(busy), 64'(0));
    tick();

    // Back-to-back: pop in the first cycle, then three consecutive writes.
    for (int i = 0; i < 3; i++) pushEntry(b2bAddr[i], b2bBe[i], b2bData[i]);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b.first_pop", 64'(bus.fifo_read), 64'(1));
    checkOutput("b2b.first_av_write", 64'(bus.av_write), 64'(0));
    checkOutput("b2b.busy", 64'(busy), 64'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkBus($sformatf("b2b[%0d]", i), b2bAddr[i], b2bBe[i], b2bData[i]);
      checkOutput($sformatf("b2b[%0d].fifo_read", i), 64'(bus.fifo_read), 64'(i < 2));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b.end_av_write", 64'(bus.av_write), 64'(0));
    checkOutput("b2b.end_busy", 64'(busy), 64'(0));
    tick();

    // Stall: first entry held for 4 waitrequest cycles while a second waits behind it.
    pushEntry(32'h200, 4'hF, 32'hDEAD);
    pushEntry(32'h300, 4'h1, 32'h55);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h202);
    checkOutput("stall.idle_chk_hit", 64'(chkHit), 64'(0));
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h202);
      checkBus($sformatf("stall[%0d]", i), 32'h200, 4'hF, 32'hDEAD);
      checkOutput($sformatf("stall[%0d].fifo_read", i), 64'(bus.fifo_read), 64'(0));
      checkOutput($sformatf("stall[%0d].chk_hit", i), 64'(chkHit), 64'(1));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h202);
    checkBus("stall.complete", 32'h200, 4'hF, 32'hDEAD);
    checkOutput("stall.complete_pop", 64'(bus.fifo_read), 64'(1));
    checkOutput("stall.err", 64'(err), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h202);
    checkBus("stall.next", 32'h300, 4'h1, 32'h55);
    checkOutput("stall.after_chk_hit", 64'(chkHit), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h202);
    checkOutput("stall.idle_av_write", 64'(bus.av_write), 64'(0));
    tick();

    // Flush with two stalled entries and a second request while pending.
    pushEntry(32'h400, 4'hF, 32'h1);
    pushEntry(32'h404, 4'hF, 32'h2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, flReq[i], flWait[i], 32'h0);
      checkOutput($sformatf("flush[%0d].flush_done", i), 64'(flushDone), 64'(i == 7));
      checkOutput($sformatf("flush[%0d].av_write", i), 64'(bus.av_write), 64'(i >= 1 && i <= 6));
      tick();
    end

    // Timeout: waitrequest stuck high; err after 8 stall cycles, sticky, write still completes.
    pushEntry(32'h500, 4'h5, 32'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("tmo[%0d].err", k), 64'(err), 64'(k >= 9));
      checkOutput($sformatf("tmo[%0d].av_write", k), 64'(bus.av_write), 64'(1));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("tmo.complete", 32'h500, 4'h5, 32'h77);
    checkOutput("tmo.complete_err", 64'(err), 64'(1));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("tmo.idle_av_write", 64'(bus.av_write), 64'(0));
    checkOutput("tmo.sticky_err", 64'(err), 64'(1));
    tick();

    // Idle flush: done on the next cycle, no bus activity.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("iflush.req_cycle_done", 64'(flushDone), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("iflush.done", 64'(flushDone), 64'(1));
    checkOutput("iflush.av_write", 64'(bus.av_write), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("iflush.single_pulse", 64'(flushDone), 64'(0));
    tick();

    // Flush request together with reset: reset wins and clears the sticky error.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstflush.done", 64'(flushDone), 64'(0));
    checkOutput("rstflush.err_cleared", 64'(err), 64'(0));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstflush.done_later", 64'(flushDone), 64'(0));
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_fifo_drain.md
# wb_fifo_drain

Write-buffer drain engine: pops packed store entries from the cache write-buffer FIFO and issues each as a single write on the Avalon-style memory bus. It sits between the write-buffer FIFO's read port and the memory bus. It sustains one write per cycle while the bus accepts. It also provides a flush handshake and an address-hit check against the in-flight entry, so the cache can detect read-after-write hazards.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- TIMEOUT, 256, number of consecutive `av_waitrequest` cycles before `err` sets; 0 disables the check
- EW (derived), AW+DW/8+DW, FIFO entry width; entry is packed {addr, byteenable, data}, addr in the MSBs

Ports:
- clk  in  1  clock; all logic on rising edge
- rest  in  1  reset; synchronous, active-high
- fifo_empty  in  1  FIFO has no entries
- fifo_read  out  1  pop strobe; combinational
- fifo_readData  in  EW  head entry; valid whenever `fifo_empty`=0
- av_address  out  AW  byte address
- av_write  out  1  write request
- av_writedata  out  DW  write data
- av_byteenable  out  DW/8  byte lanes
- av_waitrequest  in  1  bus stall
- flush_req  in  1  one-cycle pulse: drain everything
- flush_done  out  1  one-cycle pulse when a flush completes
- chk_addr  in  AW  address to check
- chk_hit  out  1  combinational; `chk_addr` matches the held entry while in WRITE
- busy  out  1  state!=IDLE or `fifo_empty`=0
- err  out  1  sticky bus-timeout flag; cleared only by `rest`

## Operation
- **Holding register** (`hold_addr`/`hold_be`/`hold_data`):
  - Drives `av_address`, `av_byteenable` and `av_writedata` directly.
  - Loaded on every pop.
- **States:**
  - IDLE: `av_write`=0.
  - WRITE: `av_write`=1.
- **Pop rule:** `fifo_read` = `!fifo_empty && (state==IDLE || (state==WRITE && !av_waitrequest))`.
- **IDLE:**
  - If `fifo_read`: load the holding register and go to WRITE.
  - Otherwise: stay in IDLE.
- **WRITE:**
  - `av_waitrequest`=1: hold all bus outputs stable and stay in WRITE.
  - `av_waitrequest`=0: the write completes. If `fifo_read`, load the next entry and stay in WRITE (back-to-back). Otherwise go to IDLE.
- **Flush:**
  - `flush_req` sets `flush_pend`.
  - When `flush_pend` is set, state==IDLE and `fifo_empty`=1: clear `flush_pend` and pulse `flush_done` in the following cycle.
  - `flush_req` arriving while already idle and empty gives `flush_done` one cycle later.
  - `flush_req` while `flush_pend` is already set is absorbed; only one `flush_done` is produced.
- **Hazard check:** `chk_hit` = (state==WRITE) && (`chk_addr[AW-1:log2(DW/8)]` == `hold_addr[AW-1:log2(DW/8)]`). The comparison is word-granular.
- **Timeout:**
  - `wait_cnt` increments each WRITE cycle with `av_waitrequest`=1 and clears on completion.
  - When `wait_cnt` reaches TIMEOUT, `err` sets.
  - The write keeps waiting; the engine never abandons or reorders entries.
  - `wait_cnt` saturates.
- **Ordering:** strict FIFO order, exactly one bus write per entry, no merging.

## Timing
- Reset (rest=1 at an edge):
  - state=IDLE, `flush_pend`=0, `wait_cnt`=0, `err`=0.
  - Holding register = 0.
  - Outputs: `av_write`=0, `flush_done`=0, `chk_hit`=0.
  - `fifo_read` is forced 0 while `rest`=1.
- Reset mid-WRITE: the in-flight write is dropped; `av_write` is 0 from the next cycle.
- Latency: `fifo_empty` falls in cycle N → pop in N, `av_write`=1 in N+1.
- Throughput: 1 entry per cycle when `av_waitrequest`=0 continuously.
- `flush_req` coinciding with the final completion (FIFO empty) → `flush_done` in the next cycle, where state==IDLE is evaluated.
- `flush_req` and `rest` in the same cycle → reset wins; no `flush_done`.

## Structure
- Shared package `cache_pkg` holds:
  - typedef `wb_entry_t` (packed struct: addr, be, data; parameterised widths via localparams AW/DW).
  - enum `drain_state_e` {IDLE, WRITE}.
- Single module, no sub-modules. Instantiated directly at the FIFO read port.

## Test plan
- **Reset:** hold `rest` 3 cycles with `fifo_empty`=0 → `fifo_read`=0, `av_write`=0, `err`=0 throughout.
- **Back-to-back:** FIFO holds 3 entries (0x100/0xF/0xA, 0x104/0x3/0xB, 0x108/0xC/0xC), `av_waitrequest`=0 → three consecutive `av_write` cycles with those values in order, then IDLE.
- **Stall:** entry 0x200/0xF/0xDEAD, `av_waitrequest`=1 for 4 cycles:
  - bus outputs stable and `fifo_read`=0 for those 4 cycles;
  - completes in the 5th `av_write` cycle;
  - `chk_addr`=0x202 gives `chk_hit`=1 during the stall and 0 after.
- **Flush:** pulse `flush_req` with 2 entries queued and the bus stalling 2 cycles each → exactly one `flush_done`, one cycle after the last completion; a second `flush_req` while pending gives no extra pulse.
- **Timeout:** TIMEOUT=8, `av_waitrequest` stuck at 1 → `err` rises after 8 stall cycles, stays 1 after the bus releases, and the write completes normally.
- **Idle flush:** `flush_req` when empty and IDLE → `flush_done` the next cycle; no `av_write`.
